instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   IF stage of the core. Owns the fetch PC and drives the combinational instruction ROM address.
//   Captures {pc, instr} pairs into a small FIFO and presents them to decode via valid/ready.
//   Accepts branch/jump redirects from execute, which flush the FIFO.
// PARAMETERS
//   RESET_PC    32'h0000_0000  fetch PC loaded on reset
//   FIFO_DEPTH  2              buffer entries; power of 2, >= 2
// PORTS
//   clk             in   1   core clock
//   rst             in   1   synchronous reset, active-high
//   imem_addr       out  32  ROM byte address; combinational = fetch_pc
//   imem_instr      in   32  ROM data, valid in the same cycle as imem_addr
//   redirect_valid  in   1   execute requests a PC change this cycle
//   redirect_pc     in   32  redirect target (byte address)
//   if_valid        out  1   FIFO head holds a valid instruction
//   if_ready        in   1   decode accepts head this cycle
//   if_instr        out  32  head instruction; 32'h0000_0013 (NOP) when empty
//   if_pc           out  32  head PC; 32'h0 when empty
//   fetch_fault     out  1   misaligned redirect seen (see CONFIGURATION)
//   fetch_fault_pc  out  32  offending redirect target
// BEHAVIOUR
//   Reset: fetch_pc=RESET_PC, FIFO count/pointers=0, FSM=FETCH, if_valid=0, if_instr=NOP, if_pc=0,
//     fetch_fault=0, fetch_fault_pc=0. imem_addr=RESET_PC while rst is high.
//   pop  = if_valid & if_ready.
//   push = FSM==FETCH & ~redirect_valid & (count<FIFO_DEPTH | pop).
//   On push: the entry {fetch_pc, imem_instr} is written at the tail and fetch_pc <= fetch_pc+4.
//   Otherwise fetch_pc holds, including when the FIFO is full with no pop.
//   Latency: cycle 0 is the first cycle after rst deasserts. The push occurs at the end of
//     cycle 0, and if_valid=1 with if_pc=RESET_PC in cycle 1. Throughput is 1 instr/cycle
//     while if_ready=1.
//   Push and pop in the same cycle: count unchanged. This is legal even when the FIFO is full.
//   Redirect has the highest priority:
//     - the FIFO is flushed (count=0, rd_ptr=wr_ptr=0) and there is no push this cycle;
//     - fetch_pc <= {redirect_pc[31:2],2'b00};
//     - a pop in the same cycle counts as consumed by decode, but the FIFO is cleared regardless;
//     - next cycle if_valid=0, and the target instruction appears with if_valid=1 two cycles
//       after the redirect cycle.
//   Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 -> 32'h0. FIFO pointers wrap modulo FIFO_DEPTH.
//   Outputs if_instr/if_pc are read from the FIFO head (storage registered, output mux
//     combinational). No combinational path from imem_instr to if_*.
//   FSM states: FETCH (normal), FAULT (no pushes; FIFO drains normally via pop).
//     FETCH -> FAULT on a misaligned redirect (macro only).
//     FAULT -> FETCH on an aligned redirect; fetch_fault stays sticky until rst.
//   rst mid-operation: everything returns to reset values next edge, and in-flight entries are
//     discarded.
// CONFIGURATION
//   FETCH_MISALIGN_TRAP_EN defined:
//     - a redirect with redirect_pc[1:0]!=0 flushes, sets fetch_fault=1 and
//       fetch_fault_pc=redirect_pc, and the FSM enters FAULT;
//     - fetch_pc is loaded with the aligned value but no fetch occurs.
//   Not defined:
//     - low bits are silently cleared and the FSM never leaves FETCH;
//     - fetch_fault/fetch_fault_pc are tied 0.
// STRUCTURE
//   Shared header rv_core_defs.vh holds:
//     - `RV_NOP (32'h0000_0013), `XLEN (32);
//     - FSM encodings FETCH_ST_FETCH=1'b0, FETCH_ST_FAULT=1'b1.
//   Sub-module fetch_fifo:
//     - synchronous FIFO of width 64 and depth FIFO_DEPTH;
//     - ports push/pop/flush/full/empty/head.
//   The top level holds the PC, FSM and push/redirect logic.
// TESTING
//   1. rst 3 cycles, if_ready=1, ROM=sequential ADDIs -> if_valid rises in cycle 1 with
//      if_pc=0; pcs 0,4,8,... consecutive with no bubbles.
//   2. if_ready=0 for 5 cycles -> count saturates at 2, imem_addr holds at 8, no entry is lost
//      or duplicated after if_ready=1.
//   3. redirect_valid with redirect_pc=0x40 while full -> next cycle if_valid=0; the cycle after
//      if_pc=0x40; stale pcs 0x4/0x8 never reach decode.
//   4. redirect_pc=0x43 -> with macro: fetch_fault=1, fetch_fault_pc=0x43, no further if_valid
//      until an aligned redirect to 0x80. Without macro: if_pc=0x40.
//   5. RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
//   6. rst asserted with 2 entries buffered -> next cycle if_valid=0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: word size, NOP encoding, FSM states, FIFO entry layout.
package instr_fetch_unit_pkg;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH_ST_FETCH = 1'b0,
        FETCH_ST_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO between fetch and decode; flush clears pointers and count in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: fetch PC, FSM, push/redirect control; buffers {pc, instr} pairs for decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fetch_fault_pc
);

    logic [XLEN-1:0] fetch_pc;
    fetch_state_e    state;
    fetch_entry_t    head;
    fetch_entry_t    tail_entry;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign pop  = if_valid & if_ready;
    assign push = (state == FETCH_ST_FETCH) & ~redirect_valid & (~full | pop);

    // Reset value is forced onto the ROM address while rst is held so the bus is defined early.
    assign imem_addr = rst ? RESET_PC : fetch_pc;

    assign tail_entry.pc    = fetch_pc;
    assign tail_entry.instr = imem_instr;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fault_q;
    logic [XLEN-1:0] fault_pc_q;
    logic            misaligned;

    assign misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            state      <= FETCH_ST_FETCH;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
            if (misaligned) begin
                state      <= FETCH_ST_FAULT;
                fault_q    <= 1'b1;
                fault_pc_q <= redirect_pc;
            end else begin
                state <= FETCH_ST_FETCH;
            end
        end else if (push) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    assign fetch_fault    = fault_q;
    assign fetch_fault_pc = fault_pc_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            state    <= FETCH_ST_FETCH;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
            state    <= FETCH_ST_FETCH;
        end else if (push) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    assign fetch_fault    = 1'b0;
    assign fetch_fault_pc = '0;
`endif

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (tail_entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Head is registered storage; only the empty-mux is combinational.
    assign if_valid = ~empty;
    assign if_instr = empty ? RV_NOP : head.instr;
    assign if_pc    = empty ? '0     : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based reference of the fetch stage.
// Honours FETCH_MISALIGN_TRAP_EN the same way as the design.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;
    logic [31:0] fetch_fault_pc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_instr = rom(imem_addr);

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault),
        .fetch_fault_pc (fetch_fault_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: queue of {pc, instr} visible to decode, plus the next fetch address.
    logic [63:0] m_q[$];
    logic [31:0] m_pc       = '0;
    bit          m_known    = 1'b0;
    bit          m_trapped  = 1'b0;
    bit          m_fault    = 1'b0;
    logic [31:0] m_fault_pc = '0;

    task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
        bit pop;
        rst            = r;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (m_known) begin
            chk("imem_addr", imem_addr, r ? RESET_PC : m_pc);
            chk("if_valid", 32'(if_valid), 32'(m_q.size() > 0));
            chk("if_pc", if_pc, (m_q.size() > 0) ? m_q[0][63:32] : 32'h0);
            chk("if_instr", if_instr, (m_q.size() > 0) ? m_q[0][31:0] : NOP);
            chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            chk("fetch_fault_pc", fetch_fault_pc, m_fault_pc);
        end
        pop = (m_q.size() > 0) && rdy;
        if (r) begin
            m_q.delete();
            m_pc       = RESET_PC;
            m_trapped  = 1'b0;
            m_fault    = 1'b0;
            m_fault_pc = '0;
            m_known    = 1'b1;
        end else begin
            if (pop)
                void'(m_q.pop_front());
            if (rv) begin
                m_q.delete();
                m_pc = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
                if (rpc[1:0] != 2'b00) begin
                    m_trapped  = 1'b1;
                    m_fault    = 1'b1;
                    m_fault_pc = rpc;
                end else begin
                    m_trapped = 1'b0;
                end
`endif
            end else if (!m_trapped && m_q.size() < DEPTH) begin
                m_q.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset, then free-running fetch across the 0xFFFF_FFFC -> 0 wrap.
        repeat (3) step(1'b1, 1'b1, 1'b0, '0);
        repeat (8) step(1'b0, 1'b1, 1'b0, '0);
        // Decode stalls long enough to fill the buffer, then resumes.
        repeat (5) step(1'b0, 1'b0, 1'b0, '0);
        repeat (4) step(1'b0, 1'b1, 1'b0, '0);
        // Redirect while full.
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        repeat (4) step(1'b0, 1'b1, 1'b0, '0);
        // Misaligned redirect, then an aligned one.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0043);
        repeat (4) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0080);
        repeat (4) step(1'b0, 1'b1, 1'b0, '0);
        // Reset with entries buffered.
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        repeat (4) step(1'b0, 1'b1, 1'b0, '0);
        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            tgt = $urandom();
            if ($urandom_range(0, 3) != 0)
                tgt = {tgt[31:8], 8'h00} | 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), tgt);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
